// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered-opcode ALU and its issue controller:
//   - ALU opcode encodings (1100-1111 are unassigned; the ALU returns 0)
//   - issue FSM state encoding
//   - entry packing helpers for the instruction FIFO
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_ADDC   = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_SUBB   = 4'b0100;
  localparam logic [3:0] OP_INC    = 4'b0101;
  localparam logic [3:0] OP_DEC    = 4'b0110;
  localparam logic [3:0] OP_PASS_B = 4'b0111;
  localparam logic [3:0] OP_OR     = 4'b1000;
  localparam logic [3:0] OP_XOR    = 4'b1001;
  localparam logic [3:0] OP_AND    = 4'b1010;
  localparam logic [3:0] OP_NOT    = 4'b1011;

  // IDLE: waiting for an instruction
  // EXEC: ALU latches the opcode presented on the load edge
  // CAPT: ALU result is valid and is captured at the end of this cycle
  // OUT : result presented downstream, held until accepted
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_CAPT = 2'b10,
    ST_OUT  = 2'b11
  } issue_state_e;

  // Width of one buffered instruction: {use_acc, op, b, a}
  function automatic int instr_width(input int data_w, input int op_w);
    return 2 * data_w + op_w + 1;
  endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// -----------------------------------------------------------------------------
// alu_instr_fifo
// Synchronous FIFO buffering issued ALU instructions. Read data is the current
// head (show-ahead), so a pop consumes the word visible on rdata_o.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (pointers/count only)
//   push_i        write wdata_i (ignored when full)
//   pop_i         drop the head entry (ignored when empty)
//   wdata_i       entry to write
//   rdata_o       current head entry
//   full_o        DEPTH entries stored
//   empty_o       no entries stored
// -----------------------------------------------------------------------------
module alu_instr_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is data only; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue stage in front of the registered-opcode ALU. Instructions are buffered
// in a FIFO, issued one at a time with operands held stable across the ALU's
// opcode register delay, and the result/carry are captured and offered
// downstream. An accumulator holding the last result can replace operand A.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        instruction handshake
//   in_a, in_b, in_op        operands and opcode
//   in_use_acc               1: operand A comes from the accumulator
//   alu_a, alu_b, alu_op     registered drive into the ALU
//   alu_q, alu_c             ALU result and carry/borrow
//   out_valid/out_ready      result handshake
//   out_q, out_c             captured result and carry/borrow
// -----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_SIZE    = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [OP_SIZE-1:0]    in_op,
  input  logic                  in_use_acc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_SIZE-1:0]    alu_op,
  input  logic [DATA_WIDTH-1:0] alu_q,
  input  logic                  alu_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  out_c
);

  localparam int ENTRY_W = instr_width(DATA_WIDTH, OP_SIZE);

  issue_state_e          state_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [OP_SIZE-1:0]    alu_op_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] out_q_q;
  logic                  out_c_q;
  logic                  out_valid_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_rdata;

  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic [OP_SIZE-1:0]    head_op;
  logic                  head_use_acc;
  logic                  issue_slot;

  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_wdata = {in_use_acc, in_op, in_b, in_a};

  assign head_a       = fifo_rdata[DATA_WIDTH-1:0];
  assign head_b       = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_op      = fifo_rdata[2*DATA_WIDTH+OP_SIZE-1:2*DATA_WIDTH];
  assign head_use_acc = fifo_rdata[ENTRY_W-1];

  // A new instruction may be issued from IDLE, or straight out of OUT on the
  // edge the current result is accepted. The FIFO has no bypass, so an entry
  // pushed this cycle is never the one popped this cycle unless already stored.
  assign issue_slot = (state_q == ST_IDLE) ||
                      ((state_q == ST_OUT) && out_ready);
  assign fifo_pop   = issue_slot && !fifo_empty;

  alu_instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue registers load only on a pop edge, so operands stay fixed through
  // EXEC and CAPT. The accumulator is always written in CAPT, which precedes
  // any following pop, so chained use_acc instructions see the fresh result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      acc_q       <= '0;
      out_q_q     <= '0;
      out_c_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (fifo_pop) begin
        alu_a_q  <= head_use_acc ? acc_q : head_a;
        alu_b_q  <= head_b;
        alu_op_q <= head_op;
      end

      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) state_q <= ST_EXEC;
        end

        ST_EXEC: begin
          state_q <= ST_CAPT;
        end

        ST_CAPT: begin
          out_q_q     <= alu_q;
          out_c_q     <= alu_c;
          acc_q       <= alu_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= fifo_pop ? ST_EXEC : ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign out_q     = out_q_q;
  assign out_c     = out_c_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_op;
  logic       in_use_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_q;
  logic       alu_c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_q;
  logic       out_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .DATA_WIDTH (8),
    .OP_SIZE    (4),
    .DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_use_acc (in_use_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_q      (alu_q),
    .alu_c      (alu_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_q      (out_q),
    .out_c      (out_c)
  );

  // Stand-in for the registered-opcode ALU: opcode latched on each edge,
  // result combinational from operands and latched opcode, carry = bit 8.
  logic [3:0] alu_op_r = 4'd0;
  logic [8:0] alu_res;

  always_ff @(posedge clk) alu_op_r <= alu_op;

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
    case (op)
      4'b0000: return {1'b0, a};
      4'b0001: return {1'b0, a} + {1'b0, b};
      4'b0010: return {1'b0, a} + {1'b0, b};
      4'b0011: return {1'b0, a} - {1'b0, b};
      4'b0100: return {1'b0, a} - {1'b0, b};
      4'b0101: return {1'b0, a} + 9'd1;
      4'b0110: return {1'b0, a} - 9'd1;
      4'b0111: return {1'b0, b};
      4'b1000: return {1'b0, a | b};
      4'b1001: return {1'b0, a ^ b};
      4'b1010: return {1'b0, a & b};
      4'b1011: return {1'b0, ~a};
      default: return 9'd0;
    endcase
  endfunction

  always_comb begin
    alu_res = alu_model(alu_a, alu_b, alu_op_r);
    alu_q   = alu_res[7:0];
    alu_c   = alu_res[8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge. ok=0 if not accepted in budget.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic ua, output bit ok);
    in_a = a; in_b = b; in_op = op; in_use_acc = ua; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Requires out_ready=1. Called at a negedge; returns at a negedge.
  task automatic get_result(output logic [7:0] q, output logic c, output bit ok);
    ok = 1'b0; q = 8'h00; c = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        q = out_q; c = out_c; ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  bit         ok;
  logic [7:0] rq;
  logic       rc;
  int         accepted;
  bit         seen_valid;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_use_acc = 1'b0; out_ready = 1'b1;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_out_q", out_q, 0);
    check("rst_alu_a", alu_a, 0);
    @(negedge clk);

    // ADD with carry, cycle-exact latency and operand stability
    push(8'hF0, 8'h20, 4'b0001, 1'b0, ok);
    check("add_accept", ok, 1);
    @(negedge clk);
    check("add_e1_valid", out_valid, 0);
    check("add_e1_alu_a", alu_a, 8'hF0);
    check("add_e1_alu_b", alu_b, 8'h20);
    check("add_e1_alu_op", alu_op, 4'b0001);
    @(negedge clk);
    check("add_e2_valid", out_valid, 0);
    check("add_e2_alu_a", alu_a, 8'hF0);
    check("add_e2_alu_b", alu_b, 8'h20);
    @(negedge clk);
    check("add_e3_valid", out_valid, 1);
    check("add_q", out_q, 8'h10);
    check("add_c", out_c, 1);
    check("add_e3_alu_a", alu_a, 8'hF0);
    @(negedge clk);
    check("add_drained", out_valid, 0);

    // SUB with borrow
    push(8'h03, 8'h05, 4'b0011, 1'b0, ok);
    get_result(rq, rc, ok);
    check("sub_ok", ok, 1);
    check("sub_q", rq, 8'hFE);
    check("sub_c", rc, 1);

    // Accumulate chain, back-to-back
    push(8'h05, 8'h00, 4'b0000, 1'b0, ok);
    push(8'h00, 8'h03, 4'b0001, 1'b1, ok);
    push(8'h00, 8'h00, 4'b0101, 1'b1, ok);
    get_result(rq, rc, ok);
    check("chain1_q", rq, 8'h05);
    get_result(rq, rc, ok);
    check("chain2_q", rq, 8'h08);
    get_result(rq, rc, ok);
    check("chain3_q", rq, 8'h09);
    check("chain3_c", rc, 0);

    // Unassigned opcode yields 0 and clears the accumulator
    push(8'hAA, 8'h55, 4'b1100, 1'b0, ok);
    get_result(rq, rc, ok);
    check("op1100_q", rq, 8'h00);
    check("op1100_c", rc, 0);
    push(8'h00, 8'h07, 4'b0001, 1'b1, ok);
    get_result(rq, rc, ok);
    check("acc_cleared_q", rq, 8'h07);

    // Backpressure
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      push(8'h10 + 8'(i), 8'h00, 4'b0000, 1'b0, ok);
      if (ok) accepted++;
    end
    check("bp_accepted", accepted, 5);
    check("bp_in_ready", in_ready, 0);
    check("bp_valid", out_valid, 1);
    check("bp_q_first", out_q, 8'h10);
    repeat (3) @(negedge clk);
    check("bp_q_held", out_q, 8'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_result(rq, rc, ok);
      check($sformatf("bp_drain%0d_ok", i), ok, 1);
      check($sformatf("bp_drain%0d_q", i), rq, 8'h10 + 8'(i));
    end

    // Reset mid-operation (in CAPT with two buffered)
    push(8'h01, 8'h01, 4'b0001, 1'b0, ok);
    push(8'h22, 8'h01, 4'b0001, 1'b0, ok);
    push(8'h33, 8'h01, 4'b0001, 1'b0, ok);
    rst = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_alu_a", alu_a, 0);
    check("mrst_out_q", out_q, 0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("mrst_fifo_empty", seen_valid, 0);
    push(8'h00, 8'h01, 4'b0001, 1'b1, ok);
    get_result(rq, rc, ok);
    check("mrst_acc_ok", ok, 1);
    check("mrst_acc_q", rq, 8'h01);
    check("mrst_acc_c", rc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the registered-opcode ALU.
- Accepts instructions (operand A, operand B, opcode, accumulate flag) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU operand and opcode inputs, holding them stable across the ALU's one-cycle opcode register delay.
- Captures the ALU result and carry and presents them downstream over a valid/ready handshake. Keeps an accumulator for chained operations.

Parameters:
- DATA_WIDTH, 8, operand/result width; must match the ALU.
- OP_SIZE, 4, opcode width; must match the ALU.
- DEPTH, 4, instruction FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  instruction accepted when in_valid & in_ready at posedge
- in_a  in  DATA_WIDTH  operand A
- in_b  in  DATA_WIDTH  operand B
- in_op  in  OP_SIZE  ALU opcode
- in_use_acc  in  1  1: use the accumulator instead of in_a as operand A
- alu_a  out  DATA_WIDTH  to ALU a_in
- alu_b  out  DATA_WIDTH  to ALU b_in
- alu_op  out  OP_SIZE  to ALU opcode
- alu_q  in  DATA_WIDTH  from ALU q_out
- alu_c  in  1  from ALU c_out
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_q  out  DATA_WIDTH  captured result
- out_c  out  1  captured carry/borrow

Behaviour:
- Reset: alu_a=0, alu_b=0, alu_op=0, out_valid=0, out_q=0, out_c=0, acc=0, FIFO empty, state IDLE, in_ready=1.
- FIFO push/pop rules:
  - in_ready = !full.
  - Push on in_valid & in_ready.
  - There is no bypass: an instruction pushed into an empty FIFO is popped at the earliest on the next edge.
  - Push and pop in the same cycle are legal; the count is unchanged.
- States are IDLE, EXEC, CAPT, OUT. All alu_* outputs are registered.
- IDLE: if FIFO non-empty, at the edge:
  - pop the head into the issue registers;
  - alu_a <= in_use_acc ? acc : a;
  - alu_b <= b; alu_op <= op;
  - go to EXEC.
- EXEC: wait state. At this edge the ALU registers alu_op. Go to CAPT unconditionally.
- CAPT: the ALU output is valid. At the edge:
  - out_q <= alu_q, out_c <= alu_c, acc <= alu_q;
  - out_valid <= 1; go to OUT.
- OUT:
  - out_q, out_c and out_valid are held stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0.
  - If the FIFO is non-empty on that same edge, pop and load the issue registers directly and go to EXEC. Otherwise go to IDLE.
- alu_a, alu_b and alu_op hold their last values outside the load edge. They are never changed during EXEC or CAPT.
- Latency: accept edge A → out_valid high after edge A+3. Sustained throughput is 1 result per 3 cycles with out_ready=1.
- The accumulator value used is the value at the pop edge. Back-to-back use_acc chains are correct because capture always precedes the next pop.
- Opcodes 1100–1111 are issued unchanged; the ALU returns 0, so the captured result is out_q=0, out_c=0 and acc is cleared.
- Carry is the ALU's 9th result bit. For subtraction it is the borrow/wrap bit, and it is passed through without interpretation.
- Reset asserted in any state: all state clears immediately to reset values. In-flight and buffered instructions are discarded.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants (OP_PASS_A=0000, OP_ADD=0001, OP_ADDC=0010, OP_SUB=0011, OP_SUBB=0100, OP_INC=0101, OP_DEC=0110, OP_PASS_B=0111, OP_OR=1000, OP_XOR=1001, OP_AND=1010, OP_NOT=1011);
  - the state encoding for IDLE/EXEC/CAPT/OUT.
- One sub-module: alu_instr_fifo, a synchronous FIFO that is DEPTH deep and DATA_WIDTH*2+OP_SIZE+1 bits wide, with full/empty flags and the same asynchronous active-low reset.
- The top level contains the FSM, issue registers, accumulator and output registers.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → in_ready=1, out_valid=0, alu_op=0, out_q=0.
- ADD with carry: a=8'hF0, b=8'h20, op=0001, out_ready=1 → out_valid after accept edge +3, out_q=8'h10, out_c=1; alu_a/alu_b stable through EXEC and CAPT.
- SUB with borrow: a=8'h03, b=8'h05, op=0011 → out_q=8'hFE, out_c=1.
- Accumulate chain, issued back-to-back:
  1. op=0000, a=8'h05 → out_q=8'h05;
  2. op=0001, use_acc=1, b=8'h03 → out_q=8'h08;
  3. op=0101, use_acc=1 → out_q=8'h09.
- Backpressure with out_ready=0: offer 6 instructions → exactly 5 accepted (4 buffered plus 1 in OUT), then in_ready=0. out_q is held stable. Releasing out_ready drains all 5 results in order.
- Reset mid-operation: assert rst while in CAPT with 2 instructions buffered → out_valid=0, FIFO empty, acc=0. After release, an op=0001 with use_acc=1 and b=8'h01 returns 8'h01.
